// File: rtl/period_meter_pkg.sv
// Shared constants and FSM state type for the period meter.
package period_meter_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned AVG_LOG2_DEF    = 2;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_e;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
      r_last <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_last;

endmodule

// File: rtl/period_meter.sv
// Measures the period of an asynchronous square wave in sys_clk cycles, averaged over
// 2^AVG_LOG2 consecutive periods, with saturation timeout and lock indication.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned AVG_LOG2    = AVG_LOG2_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             locked
);

  localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
  localparam int unsigned NS_W  = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [NS_W-1:0]  NsFull = NS_W'(2 ** AVG_LOG2);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [NS_W-1:0]  r_nsamp, w_nsamp_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic             w_valid_nxt, w_timeout_nxt, w_locked_nxt;

  logic             w_rise;
  logic             w_sat;
  logic [ACC_W-1:0] w_acc_sum;
  logic [NS_W-1:0]  w_nsamp_inc;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .d_async(sig_in),
    .rise   (w_rise)
  );

  assign w_sat       = (r_cnt == CntMax);
  assign w_acc_sum   = r_acc + ACC_W'(r_cnt);
  assign w_nsamp_inc = r_nsamp + NS_W'(1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    w_state_nxt = ARM;
        ARM:     if (w_rise) w_state_nxt = MEASURE;
        MEASURE: if (!w_rise && w_sat) w_state_nxt = ARM;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_nsamp_nxt   = r_nsamp;
    w_period_nxt  = period;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_locked_nxt  = locked;
    if (!en) begin
      // Dropping enable discards the partial window; period is held.
      w_cnt_nxt    = '0;
      w_acc_nxt    = '0;
      w_nsamp_nxt  = '0;
      w_locked_nxt = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
          w_nsamp_nxt = '0;
        end
        ARM: begin
          if (w_rise) w_cnt_nxt = CNT_W'(1);
        end
        MEASURE: begin
          if (w_rise) begin
            // An edge at full scale still counts; it takes priority over saturation.
            w_cnt_nxt = CNT_W'(1);
            if (w_nsamp_inc == NsFull) begin
              w_period_nxt = CNT_W'(w_acc_sum >> AVG_LOG2);
              w_valid_nxt  = 1'b1;
              w_locked_nxt = 1'b1;
              w_acc_nxt    = '0;
              w_nsamp_nxt  = '0;
            end else begin
              w_acc_nxt   = w_acc_sum;
              w_nsamp_nxt = w_nsamp_inc;
            end
          end else if (w_sat) begin
            w_timeout_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
            w_cnt_nxt     = '0;
            w_acc_nxt     = '0;
            w_nsamp_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
          w_nsamp_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_nsamp      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_acc        <= w_acc_nxt;
      r_nsamp      <= w_nsamp_nxt;
      period       <= w_period_nxt;
      period_valid <= w_valid_nxt;
      timeout      <= w_timeout_nxt;
      locked       <= w_locked_nxt;
    end
  end

endmodule
